// File: rtl/instr_realigner_if.sv
// Fetch-word in / instruction-slot out bus between the I$ path, the realigner and the queue.
interface instr_realigner_if;

  // Fetch side (driven upstream of the realigner) plus queue ready
  logic              flush_i;
  logic              valid_i;
  logic [31:0]       data_i;
  logic [63:0]       address_i;
  logic              ex_i;
  logic              ready_i;

  // Queue side, one entry per instruction slot, packed from slot 0
  logic [1:0]        valid_o;
  logic [1:0][31:0]  instr_o;
  logic [1:0][63:0]  addr_o;
  logic              ex_o;

  // Fetch/queue environment view
  modport master (
    output flush_i, valid_i, data_i, address_i, ex_i, ready_i,
    input  valid_o, instr_o, addr_o, ex_o
  );

  // Realigner view
  modport slave (
    input  flush_i, valid_i, data_i, address_i, ex_i, ready_i,
    output valid_o, instr_o, addr_o, ex_o
  );

endinterface

// File: rtl/instr_realigner.sv
// Splits 32-bit fetch words into up to two RVC/RV32 instruction slots and
// stitches 32-bit instructions that straddle two fetch words.
module instr_realigner #(
  parameter int unsigned INSTR_PER_FETCH = 2,
  parameter int unsigned FETCH_WIDTH     = 32
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  instr_realigner_if.slave  bus
);

  localparam int unsigned HALF_W  = 16;
  localparam int unsigned INSTR_W = 32;
  localparam int unsigned ADDR_W  = 64;
  localparam int unsigned SLOTS   = 2;

  // The halfword split below is hard-wired to a 32-bit, two-slot fetch word
  if (INSTR_PER_FETCH != 2 || FETCH_WIDTH != 32) begin : g_param_check
    $error("instr_realigner supports only INSTR_PER_FETCH=2 and FETCH_WIDTH=32");
  end

  // How the current fetch word is interpreted
  typedef enum logic [1:0] {
    KIND_EXC,      // page fault: single faulting slot
    KIND_STITCH,   // finish a 32-bit instruction from the previous word
    KIND_ODD,      // entry at the upper halfword
    KIND_ALIGNED   // fresh word starting at the lower halfword
  } kind_e;

  // Stitch state
  logic                 unaligned_q, unaligned_d;
  logic [HALF_W-1:0]    unaligned_instr_q, unaligned_instr_d;
  logic [ADDR_W-1:0]    unaligned_addr_q, unaligned_addr_d;

  // Decode of the incoming word
  logic                 present;
  logic                 accept;
  logic [HALF_W-1:0]    lo_half;
  logic [HALF_W-1:0]    hi_half;
  logic                 lo_compressed;
  logic                 hi_compressed;
  logic [ADDR_W-1:0]    base_addr;
  logic [ADDR_W-1:0]    word_addr;
  logic [ADDR_W-1:0]    hi_addr;
  kind_e                kind;

  // Slot outputs before they go onto the bus
  logic [SLOTS-1:0]               slot_valid;
  logic [SLOTS-1:0][INSTR_W-1:0]  slot_instr;
  logic [SLOTS-1:0][ADDR_W-1:0]   slot_addr;
  logic                           slot_ex;

  // Word decode; address bit 0 carries no meaning for halfword-aligned code
  assign present       = bus.valid_i & ~bus.flush_i;
  assign accept        = present & bus.ready_i;
  assign lo_half       = bus.data_i[HALF_W-1:0];
  assign hi_half       = bus.data_i[INSTR_W-1:HALF_W];
  assign lo_compressed = (lo_half[1:0] != 2'b11);
  assign hi_compressed = (hi_half[1:0] != 2'b11);
  assign base_addr     = bus.address_i & ~ADDR_W'(1);
  assign word_addr     = bus.address_i & ~ADDR_W'(3);
  assign hi_addr       = word_addr + ADDR_W'(2);

  // Exception wins, then a pending stitch, then odd entry (which drops any stale stitch)
  assign kind = bus.ex_i                           ? KIND_EXC    :
                (unaligned_q & ~bus.address_i[1])  ? KIND_STITCH :
                bus.address_i[1]                   ? KIND_ODD    :
                                                     KIND_ALIGNED;

  // Stitch state register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      unaligned_q       <= 1'b0;
      unaligned_instr_q <= '0;
      unaligned_addr_q  <= '0;
    end else begin
      unaligned_q       <= unaligned_d;
      unaligned_instr_q <= unaligned_instr_d;
      unaligned_addr_q  <= unaligned_addr_d;
    end
  end

  // Next stitch state: flush clears, an accepted word may leave its upper half pending
  always_comb begin
    unaligned_d       = unaligned_q;
    unaligned_instr_d = unaligned_instr_q;
    unaligned_addr_d  = unaligned_addr_q;
    if (bus.flush_i) begin
      unaligned_d = 1'b0;
    end else if (accept) begin
      unique case (kind)
        KIND_EXC: begin
          unaligned_d = 1'b0;
        end
        KIND_STITCH, KIND_ODD: begin
          unaligned_d = ~hi_compressed;
          if (!hi_compressed) begin
            unaligned_instr_d = hi_half;
            unaligned_addr_d  = hi_addr;
          end
        end
        KIND_ALIGNED: begin
          unaligned_d = lo_compressed & ~hi_compressed;
          if (lo_compressed && !hi_compressed) begin
            unaligned_instr_d = hi_half;
            unaligned_addr_d  = hi_addr;
          end
        end
        default: begin
          unaligned_d = 1'b0;
        end
      endcase
    end
  end

  // Slot outputs, zero latency and independent of ready
  always_comb begin
    slot_valid = '0;
    slot_instr = '0;
    slot_addr  = '0;
    slot_ex    = 1'b0;
    if (present) begin
      unique case (kind)
        KIND_EXC: begin
          slot_valid   = 2'b01;
          slot_ex      = 1'b1;
          slot_addr[0] = unaligned_q ? unaligned_addr_q : base_addr;
        end
        KIND_STITCH: begin
          slot_instr[0] = {lo_half, unaligned_instr_q};
          slot_addr[0]  = unaligned_addr_q;
          if (hi_compressed) begin
            slot_valid    = 2'b11;
            slot_instr[1] = {HALF_W'(0), hi_half};
            slot_addr[1]  = hi_addr;
          end else begin
            slot_valid    = 2'b01;
          end
        end
        KIND_ODD: begin
          if (hi_compressed) begin
            slot_valid    = 2'b01;
            slot_instr[0] = {HALF_W'(0), hi_half};
            slot_addr[0]  = hi_addr;
          end
        end
        KIND_ALIGNED: begin
          slot_addr[0] = word_addr;
          if (!lo_compressed) begin
            slot_valid    = 2'b01;
            slot_instr[0] = bus.data_i;
          end else begin
            slot_instr[0] = {HALF_W'(0), lo_half};
            if (hi_compressed) begin
              slot_valid    = 2'b11;
              slot_instr[1] = {HALF_W'(0), hi_half};
              slot_addr[1]  = hi_addr;
            end else begin
              slot_valid    = 2'b01;
            end
          end
        end
        default: begin
          slot_valid = '0;
        end
      endcase
    end
  end

  assign bus.valid_o = slot_valid;
  assign bus.instr_o = slot_instr;
  assign bus.addr_o  = slot_addr;
  assign bus.ex_o    = slot_ex;

  // Slots are packed from slot 0, so slot 1 never appears alone
  a_valid_packed: assert property (@(posedge clk_i) disable iff (!rst_ni)
                                   bus.valid_o != 2'b10)
    else $error("instr_realigner: valid_o = 10");

endmodule
